// File: rtl/trigger_bank.sv
// Bank of NCH gated AC/DC power triggers with pulse qualification and DC arbitration.
// Optional complement input is enabled by defining TRIGGER_BANK_COMP_EN.
module trigger_bank #(
    parameter int unsigned    NCH       = 4,
    parameter int unsigned    FILT      = 0,
    parameter int unsigned    DC_TIE    = 0,
    parameter logic [NCH-1:0] RESET_VAL = '0
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    input  logic [NCH-1:0] i_set_gate,
    input  logic [NCH-1:0] i_ac_set,
    input  logic [NCH-1:0] i_dc_set,
    input  logic [NCH-1:0] i_reset_gate,
    input  logic [NCH-1:0] i_ac_reset,
    input  logic [NCH-1:0] i_dc_reset,
    input  logic [NCH-1:0] i_ac_comp,
    output logic [NCH-1:0] o_out,
    output logic [NCH-1:0] o_nout,
    output logic [NCH-1:0] o_changed
);

    localparam int unsigned       CW      = 5;
    localparam logic [CW-1:0]     CNT_HIT = CW'(FILT);
    localparam logic [CW-1:0]     CNT_SAT = CW'(FILT + 1);

`ifdef TRIGGER_BANK_COMP_EN
    localparam int unsigned NQ = 3;
`else
    localparam int unsigned NQ = 2;
`endif

    logic [NQ*NCH-1:0] ac_flat;
    logic [NQ*NCH-1:0] q_flat;
    logic [NCH-1:0]    q_set;
    logic [NCH-1:0]    q_reset;
    logic [NCH-1:0]    q_comp;

    logic [NCH-1:0]    state_q;
    logic [NCH-1:0]    state_d;
    logic [NCH-1:0]    changed_q;
    logic [NCH-1:0]    dcs_low_prev_q;
    logic [NCH-1:0]    dcr_low_prev_q;
    logic [NCH-1:0]    own_set_q;
    logic [NCH-1:0]    own_set_d;
    logic [NCH-1:0]    dc_hold_q;

`ifdef TRIGGER_BANK_COMP_EN
    assign ac_flat = {i_ac_comp, i_ac_reset, i_ac_set};
    assign q_comp  = q_flat[2*NCH +: NCH];
`else
    logic unused_ac_comp;
    assign unused_ac_comp = ^i_ac_comp;
    assign ac_flat        = {i_ac_reset, i_ac_set};
    assign q_comp         = '0;
`endif

    assign q_set   = q_flat[0 +: NCH];
    assign q_reset = q_flat[NCH +: NCH];

    // Pulse qualifier: an input must be seen low after reset (armed) before it can fire.
    for (genvar k = 0; k < NQ; k++) begin : g_qual
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            logic [CW-1:0] cnt_q;
            logic          armed_q;
            logic          in_s;

            assign in_s = ac_flat[k*NCH + i];

            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    cnt_q   <= '0;
                    armed_q <= 1'b0;
                end else if (!in_s) begin
                    cnt_q   <= '0;
                    armed_q <= 1'b1;
                end else if (armed_q && (cnt_q != CNT_SAT)) begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end

            assign q_flat[k*NCH + i] = in_s & armed_q & (cnt_q == CNT_HIT);
        end
    end

    // Next state: DC levels with last-fall-wins ownership, else AC rule.
    always_comb begin
        logic sl;
        logic rl;
        logic fs;
        logic fr;
        logic win;
        state_d   = state_q;
        own_set_d = own_set_q;
        sl        = 1'b0;
        rl        = 1'b0;
        fs        = 1'b0;
        fr        = 1'b0;
        win       = 1'b0;
        for (int i = 0; i < int'(NCH); i++) begin
            sl  = ~i_dc_set[i];
            rl  = ~i_dc_reset[i];
            fs  = sl & ~dcs_low_prev_q[i];
            fr  = rl & ~dcr_low_prev_q[i];
            win = own_set_q[i];
            if (sl || rl) begin
                if (sl && rl) begin
                    if (fs && fr) begin
                        win = (DC_TIE != 0);
                    end else if (fs) begin
                        win = 1'b1;
                    end else if (fr) begin
                        win = 1'b0;
                    end
                end else begin
                    win = sl;
                end
                own_set_d[i] = win;
                state_d[i]   = win;
            end else if (!dc_hold_q[i]) begin
                if (q_comp[i]) begin
                    state_d[i] = ~state_q[i];
                end else if (state_q[i]) begin
                    state_d[i] = ~(i_reset_gate[i] & q_reset[i]);
                end else begin
                    state_d[i] = i_set_gate[i] & q_set[i];
                end
            end
        end
    end

    // Low flags reset to "high" so a DC input low at release counts as a first-cycle fall.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q        <= RESET_VAL;
            changed_q      <= '0;
            dcs_low_prev_q <= '0;
            dcr_low_prev_q <= '0;
            own_set_q      <= '0;
            dc_hold_q      <= '0;
        end else begin
            state_q        <= state_d;
            changed_q      <= state_d ^ state_q;
            dcs_low_prev_q <= ~i_dc_set;
            dcr_low_prev_q <= ~i_dc_reset;
            own_set_q      <= own_set_d;
            dc_hold_q      <= ~i_dc_set | ~i_dc_reset;
        end
    end

    assign o_out     = state_q;
    assign o_nout    = ~state_q;
    assign o_changed = changed_q;

endmodule

// File: tb/tb_trigger_bank.sv
// Directed bench for trigger_bank: instance a (FILT=0, DC_TIE=0, reset 0000)
// and instance b (FILT=2, DC_TIE=1, reset 1010).
module tb_trigger_bank;

`ifdef TRIGGER_BANK_COMP_EN
    localparam bit COMP = 1'b1;
`else
    localparam bit COMP = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] a_sg, a_as, a_ds, a_rg, a_ar, a_dr, a_ac, a_out, a_nout, a_chg;
    logic [3:0] b_sg, b_as, b_ds, b_rg, b_ar, b_dr, b_ac, b_out, b_nout, b_chg;
    int         total;
    int         bad;

    trigger_bank #(.NCH(4), .FILT(0), .DC_TIE(0), .RESET_VAL(4'b0000)) u_a (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_set_gate(a_sg), .i_ac_set(a_as), .i_dc_set(a_ds),
        .i_reset_gate(a_rg), .i_ac_reset(a_ar), .i_dc_reset(a_dr),
        .i_ac_comp(a_ac), .o_out(a_out), .o_nout(a_nout), .o_changed(a_chg)
    );

    trigger_bank #(.NCH(4), .FILT(2), .DC_TIE(1), .RESET_VAL(4'b1010)) u_b (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_set_gate(b_sg), .i_ac_set(b_as), .i_dc_set(b_ds),
        .i_reset_gate(b_rg), .i_ac_reset(b_ar), .i_dc_reset(b_dr),
        .i_ac_comp(b_ac), .o_out(b_out), .o_nout(b_nout), .o_changed(b_chg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_comp;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        a_sg = '0; a_as = '0; a_ds = '1; a_rg = '0; a_ar = '0; a_dr = '1; a_ac = '0;
        b_sg = '0; b_as = '0; b_ds = '1; b_rg = '0; b_ar = '0; b_dr = '1; b_ac = '0;

        // Reset values
        #11;
        chk("rst_a_out", a_out, 4'b0000);
        chk("rst_a_nout", a_nout, 4'b1111);
        chk("rst_a_chg", a_chg, 4'b0000);
        chk("rst_b_out", b_out, 4'b1010);
        chk("rst_b_nout", b_nout, 4'b0101);
        #1 rst_n = 1'b1;
        tick();

        // FILT=0 set acts on the first high sample
        a_sg = 4'b0001; a_as = 4'b0001;
        tick();
        chk("t1_out", a_out, 4'b0001);
        chk("t1_nout", a_nout, 4'b1110);
        chk("t1_chg", a_chg, 4'b0001);
        tick();
        chk("t1_out_hold", a_out, 4'b0001);
        chk("t1_chg_drop", a_chg, 4'b0000);
        a_sg = '0; a_as = '0;
        tick();

        // FILT=2: two-cycle pulse ignored, three-cycle pulse fires once
        b_sg = 4'b0001; b_as = 4'b0001;
        tick(); tick();
        b_as = '0;
        tick();
        chk("t2_short", b_out, 4'b1010);
        b_as = 4'b0001;
        tick(); tick();
        chk("t2_edge2", b_out, 4'b1010);
        tick();
        chk("t2_edge3", b_out, 4'b1011);
        chk("t2_chg", b_chg, 4'b0001);
        tick();
        chk("t2_once", b_out, 4'b1011);
        chk("t2_chg_drop", b_chg, 4'b0000);
        b_as = '0;
        tick();

        // DC arbitration on a ch1
        a_ds = 4'b1101;
        tick();
        chk("t3_dcset", a_out, 4'b0011);
        tick(); tick();
        a_dr = 4'b1101;
        tick();
        chk("t3_dcrst_later", a_out, 4'b0001);
        a_dr = 4'b1111;
        tick();
        chk("t3_rst_release", a_out, 4'b0011);
        a_ds = 4'b1111;
        tick();
        chk("t3_both_release", a_out, 4'b0011);
        a_ds = 4'b1101; a_dr = 4'b1101;
        tick();
        chk("t3_tie_reset", a_out, 4'b0001);
        a_ds = 4'b1111; a_dr = 4'b1111;
        tick();
        chk("t3_tie_hold", a_out, 4'b0001);

        // DC_TIE=1 on b ch2
        b_ds = 4'b1011; b_dr = 4'b1011;
        tick();
        chk("t3_tie_set", b_out, 4'b1111);
        b_ds = 4'b1111; b_dr = 4'b1111;
        tick();
        chk("t3b_hold", b_out, 4'b1111);

        // Simultaneous gated set/reset toggles a ch0
        a_sg = 4'b0001; a_rg = 4'b0001;
        a_as = 4'b0001; a_ar = 4'b0001;
        tick();
        chk("t4_toggle0", a_out, 4'b0000);
        a_as = '0; a_ar = '0;
        tick();
        a_as = 4'b0001; a_ar = 4'b0001;
        tick();
        chk("t4_toggle1", a_out, 4'b0001);
        a_as = '0; a_ar = '0;
        tick();
        a_rg = '0; a_ar = 4'b0001;
        tick();
        chk("t4_gate_closed", a_out, 4'b0001);
        a_ar = '0; a_sg = '0;
        tick();

        // Async reset mid-pulse, input held high through release
        b_sg = 4'b1111; b_as = 4'b1111;
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_async_b", b_out, 4'b1010);
        chk("t5_async_a", a_out, 4'b0000);
        chk("t5_async_chg", b_chg, 4'b0000);
        #1 rst_n = 1'b1;
        tick(); tick(); tick(); tick();
        chk("t5_held_high", b_out, 4'b1010);
        b_as = '0;
        tick();
        b_as = 4'b1111;
        tick(); tick();
        chk("t5_rearm_edge2", b_out, 4'b1010);
        tick();
        chk("t5_rearm_edge3", b_out, 4'b1111);
        chk("t5_rearm_chg", b_chg, 4'b0101);
        b_as = '0; b_sg = '0;
        tick();

        // Complement input: toggles only when enabled
        for (int n = 1; n <= 4; n++) begin
            a_ac = 4'b0001;
            tick();
            exp_comp = (COMP && (n % 2 == 1)) ? 4'b0001 : 4'b0000;
            chk($sformatf("t6_comp%0d", n), a_out, exp_comp);
            a_ac = '0;
            tick();
        end
        a_dr = 4'b1110; a_ac = 4'b0001;
        tick();
        chk("t6_comp_dc", a_out, 4'b0000);
        a_dr = '1; a_ac = '0;
        tick();
        chk("t6_final_nout", a_nout, 4'b1111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
